// File: rtl/load_store_unit.sv
// Load/store unit: CPU-side initiator for the data port of the byte-addressed
// memory block. It accepts one MIPS load/store per handshake, computes and checks
// the effective address, and drives the memory port for exactly one cycle. It
// merges LWL/LWR data with the old rt value and returns a write-back response.
//
// Handshake rules (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. The request side is ready only in IDLE. A
// response stays valid and stable until resp_ready is seen. Leaving RESP never
// accepts a new request in the same cycle.
module load_store_unit #(
    parameter int ADDR_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_base,
    input  logic [15:0] req_offset,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_reg,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic [2:0]  mem_write_mode,
    output logic [2:0]  mem_read_mode,
    output logic        mem_unsigned,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_reg,
    output logic        resp_we,
    output logic        resp_fault,
    output logic [31:0] resp_fault_addr,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [2:0] M_NONE  = 3'd0;
    localparam logic [2:0] M_BYTE  = 3'd1;
    localparam logic [2:0] M_HALF  = 3'd2;
    localparam logic [2:0] M_WORD  = 3'd3;
    localparam logic [2:0] M_LEFT  = 3'd4;
    localparam logic [2:0] M_RIGHT = 3'd5;

    typedef struct packed {
        logic       ok;     // defined op code
        logic       load;   // produces a register write-back
        logic [2:0] wmode;
        logic [2:0] rmode;
        logic       uns;
        logic [1:0] align;  // EA bits that must be zero
    } dec_t;

    function automatic dec_t decode(input logic [3:0] op);
        dec_t d;
        d = '{ok: 1'b1, load: 1'b0, wmode: M_NONE, rmode: M_NONE, uns: 1'b0, align: 2'b00};
        case (op)
            4'd0:  begin d.load = 1'b1; d.rmode = M_BYTE; end
            4'd1:  begin d.load = 1'b1; d.rmode = M_BYTE; d.uns = 1'b1; end
            4'd2:  begin d.load = 1'b1; d.rmode = M_HALF; d.align = 2'b01; end
            4'd3:  begin d.load = 1'b1; d.rmode = M_HALF; d.uns = 1'b1; d.align = 2'b01; end
            4'd4:  begin d.load = 1'b1; d.rmode = M_WORD; d.align = 2'b11; end
            4'd5:  begin d.load = 1'b1; d.rmode = M_LEFT; end
            4'd6:  begin d.load = 1'b1; d.rmode = M_RIGHT; end
            4'd8:  d.wmode = M_BYTE;
            4'd9:  begin d.wmode = M_HALF; d.align = 2'b01; end
            4'd10: begin d.wmode = M_WORD; d.align = 2'b11; end
            4'd11: d.wmode = M_LEFT;
            4'd12: d.wmode = M_RIGHT;
            default: d.ok = 1'b0;
        endcase
        return d;
    endfunction

    // LWL keeps the low rt bytes below the loaded part; LWR keeps the high ones.
    // Memory already zero-fills the lanes it does not return.
    function automatic logic [31:0] merge(input logic [3:0] op, input logic [1:0] k,
                                          input logic [31:0] rd, input logic [31:0] rt);
        logic [31:0] keep;
        keep = 32'h0;
        case (op)
            4'd5:    keep = 32'h00FF_FFFF >> {k, 3'b000};
            4'd6:    keep = ~(32'hFFFF_FFFF >> {k, 3'b000});
            default: keep = 32'h0;
        endcase
        return (rd & ~keep) | (rt & keep);
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] ea_q, ea_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  reg_q, reg_d;
    logic        req_ready_q, req_ready_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic [2:0]  mem_write_mode_q, mem_write_mode_d;
    logic [2:0]  mem_read_mode_q, mem_read_mode_d;
    logic        mem_unsigned_q, mem_unsigned_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [4:0]  resp_reg_q, resp_reg_d;
    logic        resp_we_q, resp_we_d;
    logic        resp_fault_q, resp_fault_d;
    logic [31:0] resp_fault_addr_q, resp_fault_addr_d;

    logic [31:0] req_ea;
    dec_t        req_dec;
    dec_t        cur_dec;
    logic        req_fault;

    assign req_ea    = req_base + {{16{req_offset[15]}}, req_offset};
    assign req_dec   = decode(req_op);
    assign cur_dec   = decode(op_q);
    assign req_fault = !req_dec.ok
                     || ((req_ea >> ADDR_W) != 32'd0)
                     || ((req_ea[1:0] & req_dec.align) != 2'b00);

    // Next-state and next-output computation for the whole unit.
    always_comb begin
        state_d           = state_q;
        op_d              = op_q;
        ea_d              = ea_q;
        wdata_d           = wdata_q;
        reg_d             = reg_q;
        req_ready_d       = req_ready_q;
        mem_address_d     = mem_address_q;
        mem_data_d        = mem_data_q;
        mem_write_mode_d  = mem_write_mode_q;
        mem_read_mode_d   = mem_read_mode_q;
        mem_unsigned_d    = mem_unsigned_q;
        resp_valid_d      = resp_valid_q;
        resp_data_d       = resp_data_q;
        resp_reg_d        = resp_reg_q;
        resp_we_d         = resp_we_q;
        resp_fault_d      = resp_fault_q;
        resp_fault_addr_d = resp_fault_addr_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d        = req_op;
                    ea_d        = req_ea;
                    wdata_d     = req_wdata;
                    reg_d       = req_reg;
                    req_ready_d = 1'b0;
                    if (req_fault) begin
                        // Faults never touch memory; respond on the next edge.
                        state_d           = S_RESP;
                        resp_valid_d      = 1'b1;
                        resp_data_d       = 32'h0;
                        resp_reg_d        = req_reg;
                        resp_we_d         = 1'b0;
                        resp_fault_d      = 1'b1;
                        resp_fault_addr_d = req_ea;
                    end else begin
                        state_d          = S_ISSUE;
                        mem_address_d    = req_ea;
                        mem_data_d       = req_wdata;
                        mem_write_mode_d = req_dec.wmode;
                        mem_read_mode_d  = req_dec.rmode;
                        mem_unsigned_d   = req_dec.uns;
                    end
                end
            end
            S_ISSUE: begin
                // The store commits and the load data is captured on this edge.
                state_d          = S_RESP;
                mem_address_d    = 32'h0;
                mem_data_d       = 32'h0;
                mem_write_mode_d = M_NONE;
                mem_read_mode_d  = M_NONE;
                mem_unsigned_d   = 1'b0;
                resp_valid_d     = 1'b1;
                resp_reg_d       = reg_q;
                resp_we_d        = cur_dec.load;
                resp_fault_d     = 1'b0;
                resp_fault_addr_d = 32'h0;
                resp_data_d      = cur_dec.load ? merge(op_q, ea_q[1:0], mem_rdata, wdata_q)
                                                : 32'h0;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d           = S_IDLE;
                    req_ready_d       = 1'b1;
                    resp_valid_d      = 1'b0;
                    resp_data_d       = 32'h0;
                    resp_reg_d        = 5'd0;
                    resp_we_d         = 1'b0;
                    resp_fault_d      = 1'b0;
                    resp_fault_addr_d = 32'h0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs; async reset drops the memory modes at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= S_IDLE;
            op_q              <= 4'd0;
            ea_q              <= 32'h0;
            wdata_q           <= 32'h0;
            reg_q             <= 5'd0;
            req_ready_q       <= 1'b1;
            mem_address_q     <= 32'h0;
            mem_data_q        <= 32'h0;
            mem_write_mode_q  <= M_NONE;
            mem_read_mode_q   <= M_NONE;
            mem_unsigned_q    <= 1'b0;
            resp_valid_q      <= 1'b0;
            resp_data_q       <= 32'h0;
            resp_reg_q        <= 5'd0;
            resp_we_q         <= 1'b0;
            resp_fault_q      <= 1'b0;
            resp_fault_addr_q <= 32'h0;
        end else begin
            state_q           <= state_d;
            op_q              <= op_d;
            ea_q              <= ea_d;
            wdata_q           <= wdata_d;
            reg_q             <= reg_d;
            req_ready_q       <= req_ready_d;
            mem_address_q     <= mem_address_d;
            mem_data_q        <= mem_data_d;
            mem_write_mode_q  <= mem_write_mode_d;
            mem_read_mode_q   <= mem_read_mode_d;
            mem_unsigned_q    <= mem_unsigned_d;
            resp_valid_q      <= resp_valid_d;
            resp_data_q       <= resp_data_d;
            resp_reg_q        <= resp_reg_d;
            resp_we_q         <= resp_we_d;
            resp_fault_q      <= resp_fault_d;
            resp_fault_addr_q <= resp_fault_addr_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign mem_address     = mem_address_q;
    assign mem_data        = mem_data_q;
    assign mem_write_mode  = mem_write_mode_q;
    assign mem_read_mode   = mem_read_mode_q;
    assign mem_unsigned    = mem_unsigned_q;
    assign resp_valid      = resp_valid_q;
    assign resp_data       = resp_data_q;
    assign resp_reg        = resp_reg_q;
    assign resp_we         = resp_we_q;
    assign resp_fault      = resp_fault_q;
    assign resp_fault_addr = resp_fault_addr_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural little-endian byte memory, a vector
// table of load/store operations with hand-derived results, and hand-written
// sequences for response back-pressure and reset during ISSUE.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_base;
  logic [15:0] req_offset;
  logic [31:0] req_wdata;
  logic [4:0]  req_reg;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic [2:0]  mem_write_mode;
  logic [2:0]  mem_read_mode;
  logic        mem_unsigned;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_reg;
  logic        resp_we;
  logic        resp_fault;
  logic [31:0] resp_fault_addr;
  logic [1:0]  dbg_state;

  load_store_unit #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata), .req_reg(req_reg),
    .mem_address(mem_address), .mem_data(mem_data), .mem_write_mode(mem_write_mode),
    .mem_read_mode(mem_read_mode), .mem_unsigned(mem_unsigned), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_reg(resp_reg), .resp_we(resp_we), .resp_fault(resp_fault),
    .resp_fault_addr(resp_fault_addr), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [7:0] mem [0:65535];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    logic [15:0] a;
    logic [15:0] a0;
    int k;
    a  = mem_address[15:0];
    a0 = {a[15:2], 2'b00};
    k  = int'(a[1:0]);
    case (mem_write_mode)
      3'd1: mem[a] <= mem_data[7:0];
      3'd2: begin mem[a] <= mem_data[7:0]; mem[a + 16'd1] <= mem_data[15:8]; end
      3'd3: for (int j = 0; j < 4; j++) mem[a0 + 16'(j)] <= mem_data[8*j +: 8];
      3'd4: for (int j = 0; j < 4; j++) if (j <= k) mem[a0 + 16'(j)] <= mem_data[8*(3-k+j) +: 8];
      3'd5: for (int j = 0; j < 4; j++) if (j >= k) mem[a0 + 16'(j)] <= mem_data[8*(j-k) +: 8];
      default: ;
    endcase
  end

  always_comb begin
    logic [15:0] a;
    logic [15:0] a0;
    logic [7:0]  b;
    logic [15:0] h;
    int k;
    mem_rdata = 32'h0;
    a  = mem_address[15:0];
    a0 = {a[15:2], 2'b00};
    k  = int'(a[1:0]);
    b  = mem[a];
    h  = {mem[a + 16'd1], mem[a]};
    case (mem_read_mode)
      3'd1: mem_rdata = mem_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
      3'd2: mem_rdata = mem_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
      3'd3: mem_rdata = {mem[a0 + 16'd3], mem[a0 + 16'd2], mem[a0 + 16'd1], mem[a0]};
      3'd4: for (int j = 0; j < 4; j++) if (j <= k) mem_rdata[8*(3-k+j) +: 8] = mem[a0 + 16'(j)];
      3'd5: for (int j = 0; j < 4; j++) if (j >= k) mem_rdata[8*(j-k) +: 8] = mem[a0 + 16'(j)];
      default: mem_rdata = 32'h0;
    endcase
  end

  // ---------------- scoreboard ----------------
  // {fault, we, reg, data, fault_addr}
  logic [70:0] exp_q[$];
  int compares = 0;
  int mismatches = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      mismatches++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] base;
    logic [15:0] off;
    logic [31:0] wdata;
    logic [4:0]  rreg;
    logic [31:0] ea;
    logic        fault;
    logic [2:0]  wmode;
    logic [2:0]  rmode;
    logic        uns;
    logic [31:0] data;
    logic        we;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] base, input logic [15:0] off,
                              input logic [31:0] wd, input logic [31:0] ea, input logic flt,
                              input logic [2:0] wm, input logic [2:0] rm, input logic uns,
                              input logic [31:0] data, input logic we);
    vec_t v;
    v.op = op; v.base = base; v.off = off; v.wdata = wd; v.ea = ea; v.fault = flt;
    v.wmode = wm; v.rmode = rm; v.uns = uns; v.data = data; v.we = we;
    v.rreg = 5'($urandom_range(1, 31));
    return v;
  endfunction

  // ---------------- driver ----------------
  logic aborted = 1'b0;

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  endtask

  task automatic run_vec(input vec_t v, input int hold);
    int cyc;
    int active;
    logic done;
    logic [70:0] e;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_op     = v.op;
    req_base   = v.base;
    req_offset = v.off;
    req_wdata  = v.wdata;
    req_reg    = v.rreg;
    exp_q.push_back({v.fault, v.we, v.rreg, v.data, v.fault ? v.ea : 32'h0});
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_op     = 4'($urandom_range(0, 15));
    req_base   = $urandom;
    req_offset = 16'($urandom);
    req_wdata  = $urandom;
    req_reg    = 5'($urandom_range(0, 31));
    cyc = 0;
    active = 0;
    done = 1'b0;
    while (!done && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (mem_write_mode != 3'd0 || mem_read_mode != 3'd0) begin
        active++;
        check("issue_addr", mem_address, v.ea);
        check("issue_data", mem_data, v.wdata);
        check("issue_wmode", 32'(mem_write_mode), 32'(v.wmode));
        check("issue_rmode", 32'(mem_read_mode), 32'(v.rmode));
        check("issue_unsigned", 32'(mem_unsigned), 32'(v.uns));
        check("issue_req_ready", 32'(req_ready), 32'd0);
      end
      if (resp_valid) done = 1'b1;
    end
    if (!done) begin
      compares++;
      mismatches++;
      $display("FAIL resp_timeout: got no resp_valid in %0d cycles want response", cyc);
      aborted = 1'b1;
      return;
    end
    check("latency", 32'(cyc), v.fault ? 32'd1 : 32'd2);
    check("mode_cycles", 32'(active), v.fault ? 32'd0 : 32'd1);
    e = exp_q.pop_front();
    check("resp_fault", 32'(resp_fault), 32'(e[70]));
    check("resp_we", 32'(resp_we), 32'(e[69]));
    check("resp_reg", 32'(resp_reg), 32'(e[68:64]));
    check("resp_data", resp_data, e[63:32]);
    check("resp_fault_addr", resp_fault_addr, e[31:0]);
    // Back-pressure: a competing request is offered and must be ignored.
    for (int h = 0; h < hold; h++) begin
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_op     = 4'd10;
      req_base   = 32'h600;
      req_offset = 16'h0;
      req_wdata  = 32'hBAD0BAD0;
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_data", resp_data, e[63:32]);
      check("hold_reg", 32'(resp_reg), 32'(e[68:64]));
      check("hold_fault", 32'(resp_fault), 32'(e[70]));
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_modes", 32'({mem_write_mode, mem_read_mode}), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    @(negedge clk);
    check("post_valid", 32'(resp_valid), 32'd0);
    check("post_data", resp_data, 32'h0);
    check("post_flags", 32'({resp_we, resp_fault, resp_reg}), 32'd0);
    check("post_fault_addr", resp_fault_addr, 32'h0);
    check("post_req_ready", 32'(req_ready), 32'd1);
    check("post_modes", 32'({mem_write_mode, mem_read_mode}), 32'd0);
  endtask

  // ---------------- test ----------------
  vec_t vecs[$];

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_op     = 4'd0;
    req_base   = 32'h0;
    req_offset = 16'h0;
    req_wdata  = 32'h0;
    req_reg    = 5'd0;
    resp_ready = 1'b0;

    vecs.push_back(mk(4'd10, 32'h100,   16'h0004, 32'hDEADBEEF, 32'h104,   1'b0, 3'd3, 3'd0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(4'd4,  32'h104,   16'h0000, 32'h5A5A0001, 32'h104,   1'b0, 3'd0, 3'd3, 1'b0, 32'hDEADBEEF, 1'b1));
    vecs.push_back(mk(4'd8,  32'h10,    16'h0000, 32'h00000080, 32'h10,    1'b0, 3'd1, 3'd0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(4'd0,  32'h20,    16'hFFF0, 32'h0,        32'h10,    1'b0, 3'd0, 3'd1, 1'b0, 32'hFFFFFF80, 1'b1));
    vecs.push_back(mk(4'd1,  32'h10,    16'h0000, 32'h0,        32'h10,    1'b0, 3'd0, 3'd1, 1'b1, 32'h00000080, 1'b1));
    vecs.push_back(mk(4'd9,  32'h40,    16'h0002, 32'h1234ABCD, 32'h42,    1'b0, 3'd2, 3'd0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(4'd2,  32'h40,    16'h0002, 32'h0,        32'h42,    1'b0, 3'd0, 3'd2, 1'b0, 32'hFFFFABCD, 1'b1));
    vecs.push_back(mk(4'd3,  32'h44,    16'hFFFE, 32'h0,        32'h42,    1'b0, 3'd0, 3'd2, 1'b1, 32'h0000ABCD, 1'b1));
    vecs.push_back(mk(4'd4,  32'h100,   16'h0002, 32'h0,        32'h102,   1'b1, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(4'd4,  32'hFFFC,  16'h0004, 32'h0,        32'h10000, 1'b1, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(4'd2,  32'h41,    16'h0000, 32'h0,        32'h41,    1'b1, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(4'd10, 32'h106,   16'h0000, 32'h55555555, 32'h106,   1'b1, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(4'd8,  32'h10000, 16'h0000, 32'h00000077, 32'h10000, 1'b1, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(4'd7,  32'h300,   16'h0000, 32'h0,        32'h300,   1'b1, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(4'd13, 32'h304,   16'h0000, 32'h0,        32'h304,   1'b1, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(4'd4,  32'h0,     16'hFFFC, 32'h0,        32'hFFFFFFFC, 1'b1, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(4'd4,  32'h104,   16'h0000, 32'h0,        32'h104,   1'b0, 3'd0, 3'd3, 1'b0, 32'hDEADBEEF, 1'b1));
    vecs.push_back(mk(4'd4,  32'hFFFC,  16'h0000, 32'h0,        32'hFFFC,  1'b0, 3'd0, 3'd3, 1'b0, 32'h0, 1'b1));
    vecs.push_back(mk(4'd10, 32'h200,   16'h0000, 32'h11223344, 32'h200,   1'b0, 3'd3, 3'd0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(4'd5,  32'h200,   16'h0000, 32'hAABBCCDD, 32'h200,   1'b0, 3'd0, 3'd4, 1'b0, 32'h44BBCCDD, 1'b1));
    vecs.push_back(mk(4'd5,  32'h200,   16'h0001, 32'hAABBCCDD, 32'h201,   1'b0, 3'd0, 3'd4, 1'b0, 32'h3344CCDD, 1'b1));
    vecs.push_back(mk(4'd5,  32'h200,   16'h0002, 32'hAABBCCDD, 32'h202,   1'b0, 3'd0, 3'd4, 1'b0, 32'h223344DD, 1'b1));
    vecs.push_back(mk(4'd5,  32'h200,   16'h0003, 32'hAABBCCDD, 32'h203,   1'b0, 3'd0, 3'd4, 1'b0, 32'h11223344, 1'b1));
    vecs.push_back(mk(4'd6,  32'h200,   16'h0000, 32'hAABBCCDD, 32'h200,   1'b0, 3'd0, 3'd5, 1'b0, 32'h11223344, 1'b1));
    vecs.push_back(mk(4'd6,  32'h200,   16'h0001, 32'hAABBCCDD, 32'h201,   1'b0, 3'd0, 3'd5, 1'b0, 32'hAA112233, 1'b1));
    vecs.push_back(mk(4'd6,  32'h200,   16'h0002, 32'hAABBCCDD, 32'h202,   1'b0, 3'd0, 3'd5, 1'b0, 32'hAABB1122, 1'b1));
    vecs.push_back(mk(4'd6,  32'h200,   16'h0003, 32'hAABBCCDD, 32'h203,   1'b0, 3'd0, 3'd5, 1'b0, 32'hAABBCC11, 1'b1));
    vecs.push_back(mk(4'd11, 32'h300,   16'h0001, 32'hA1B2C3D4, 32'h301,   1'b0, 3'd4, 3'd0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(4'd12, 32'h300,   16'h0006, 32'hA1B2C3D4, 32'h306,   1'b0, 3'd5, 3'd0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(4'd4,  32'h300,   16'h0000, 32'h0,        32'h300,   1'b0, 3'd0, 3'd3, 1'b0, 32'h0000A1B2, 1'b1));
    vecs.push_back(mk(4'd4,  32'h300,   16'h0004, 32'h0,        32'h304,   1'b0, 3'd0, 3'd3, 1'b0, 32'hC3D40000, 1'b1));
    vecs.push_back(mk(4'd4,  32'h600,   16'h0000, 32'h0,        32'h600,   1'b0, 3'd0, 3'd3, 1'b0, 32'h0, 1'b1));

    // Reset values, checked while reset is still asserted.
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp", 32'({resp_valid, resp_we, resp_fault, resp_reg}), 32'd0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_modes", 32'({mem_write_mode, mem_read_mode, mem_unsigned}), 32'd0);
    check("rst_mem_addr", mem_address, 32'h0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], (i == 1) ? 5 : int'($urandom_range(0, 2)));
      if (aborted) finish_run();
    end

    // Reset asserted in the middle of a word store: nothing may be written.
    @(negedge clk);
    req_valid  = 1'b1;
    req_op     = 4'd10;
    req_base   = 32'h500;
    req_offset = 16'h0;
    req_wdata  = 32'h12345678;
    req_reg    = 5'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_issue_wmode", 32'(mem_write_mode), 32'd3);
    check("mid_issue_state", 32'(dbg_state), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_modes", 32'({mem_write_mode, mem_read_mode}), 32'd0);
    check("rst_async_addr", mem_address, 32'h0);
    check("rst_async_data", mem_data, 32'h0);
    check("rst_async_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("rst_no_resp", 32'(resp_valid), 32'd0);
    check("rst_mem_unchanged", {mem[16'h503], mem[16'h502], mem[16'h501], mem[16'h500]}, 32'h0);
    rst = 1'b1;
    run_vec(mk(4'd4, 32'h500, 16'h0000, 32'h0, 32'h500, 1'b0, 3'd0, 3'd3, 1'b0, 32'h0, 1'b1), 0);
    if (aborted) finish_run();

    repeat (2) @(negedge clk);
    finish_run();
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    mismatches++;
    finish_run();
  end

endmodule
